// File: rtl/vga_mode_ctrl_pkg.sv
// Shared types for the vga mode sequencer: FSM encodings, the modeline record and its validity limits.
package vga_mode_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_VB = 3'd1,
    S_RESET   = 3'd2,
    S_SETTLE  = 3'd3,
    S_RUN     = 3'd4
  } state_t;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
    logic [7:0]  hfp;
    logic [7:0]  hs;
    logic [7:0]  hbp;
    logic [7:0]  vfp;
    logic [7:0]  vs;
    logic [7:0]  vbp;
    logic [7:0]  interlaced;
  } modeline_t;

  localparam logic [15:0] MODE_H_MIN = 16'd1;
  localparam logic [15:0] MODE_V_MIN = 16'd1;

  function automatic logic mode_ok(input logic [15:0] h, input logic [15:0] v);
    return (h >= MODE_H_MIN) && (v >= MODE_V_MIN);
  endfunction

endpackage

// File: rtl/vga_mode_ctrl_if.sv
// Bundle between host/vga side and the mode sequencer; slave is the sequencer, master drives its inputs.
interface vga_mode_ctrl_if;
  logic        mode_valid, mode_ready, mode_hard;
  logic [15:0] mode_h, mode_v;
  logic [7:0]  mode_hfp, mode_hs, mode_hbp, mode_vfp, mode_vs, mode_vbp, mode_interlaced;
  logic [15:0] H, V;
  logic [7:0]  HFP, HS, HBP, VFP, VS, VBP, interlaced;
  logic        vga_reset, vga_soft_reset, vga_frame_reset, vram_reset, vga_wait_vblank, vram_active;
  logic        vblank, vram_ready, vram_end_frame, vram_synced;
  logic        pix_valid, pix_ready, vram_req;
  logic [23:0] pix_rgb;
  logic [7:0]  r_vram_in, g_vram_in, b_vram_in;
  logic        frame_done, mode_err;
  logic [15:0] desync_cnt;
  logic [2:0]  state;

  modport slave (
    input  mode_valid, mode_hard, mode_h, mode_v, mode_hfp, mode_hs, mode_hbp,
           mode_vfp, mode_vs, mode_vbp, mode_interlaced,
           vblank, vram_ready, vram_end_frame, vram_synced, pix_valid, pix_rgb,
    output mode_ready, H, V, HFP, HS, HBP, VFP, VS, VBP, interlaced,
           vga_reset, vga_soft_reset, vga_frame_reset, vram_reset, vga_wait_vblank, vram_active,
           pix_ready, vram_req, r_vram_in, g_vram_in, b_vram_in,
           frame_done, mode_err, desync_cnt, state
  );

  modport master (
    output mode_valid, mode_hard, mode_h, mode_v, mode_hfp, mode_hs, mode_hbp,
           mode_vfp, mode_vs, mode_vbp, mode_interlaced,
           vblank, vram_ready, vram_end_frame, vram_synced, pix_valid, pix_rgb,
    input  mode_ready, H, V, HFP, HS, HBP, VFP, VS, VBP, interlaced,
           vga_reset, vga_soft_reset, vga_frame_reset, vram_reset, vga_wait_vblank, vram_active,
           pix_ready, vram_req, r_vram_in, g_vram_in, b_vram_in,
           frame_done, mode_err, desync_cnt, state
  );
endinterface

// File: rtl/vga_mode_ctrl_pixreg.sv
// Pixel request register: one accepted pixel becomes a one-cycle vram_req next cycle, data held until the next accept.
// At most one request outstanding, so throughput is one pixel per two clocks; stalls while closed or vram not ready.
module vga_mode_ctrl_pixreg (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        open,
  input  logic        vram_ready,
  input  logic        pix_valid,
  input  logic [23:0] pix_rgb,
  output logic        pix_ready,
  output logic        vram_req,
  output logic [7:0]  r_vram_in,
  output logic [7:0]  g_vram_in,
  output logic [7:0]  b_vram_in
);

  logic take;

  assign pix_ready = open && vram_ready && !vram_req;
  assign take      = pix_valid && pix_ready;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      vram_req  <= 1'b0;
      r_vram_in <= '0;
      g_vram_in <= '0;
      b_vram_in <= '0;
    end else begin
      vram_req <= take;
      if (take) begin
        r_vram_in <= pix_rgb[23:16];
        g_vram_in <= pix_rgb[15:8];
        b_vram_in <= pix_rgb[7:0];
      end
    end
  end

endmodule

// File: rtl/vga_mode_ctrl.sv
// Mode sequencer: applies modelines at vblank (soft) or at once (hard), sequences vga resets, paces pixels.
// Optional GROOVY_VGA_AUTORESYNC_EN: a desync in run re-applies the active timing at the next vblank.
module vga_mode_ctrl
  import vga_mode_ctrl_pkg::*;
#(
  parameter int          RESET_CYCLES  = 4,
  parameter int          SETTLE_CYCLES = 2,
  parameter logic [23:0] WAIT_TIMEOUT  = 24'h400000
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  vga_mode_ctrl_if.slave  bus
);

  localparam logic [23:0] RESET_LAST  = 24'(RESET_CYCLES - 1);
  localparam logic [23:0] SETTLE_LAST = (SETTLE_CYCLES > 0) ? 24'(SETTLE_CYCLES - 1) : 24'd0;
  localparam logic [23:0] WAIT_LAST   = WAIT_TIMEOUT - 24'd1;

  state_t      state, state_nxt;
  logic        hard, hard_nxt;
  logic [23:0] cnt;
  modeline_t   shadow, active, mode_in;
  logic        vblank_q, end_frame_q, synced_q;
  logic        mode_err_q, frame_done_q, wait_vb_q;
  logic [15:0] desync_q;
  logic        accept, mode_good, desync, pix_open;

  assign mode_in = '{h: bus.mode_h, v: bus.mode_v, hfp: bus.mode_hfp, hs: bus.mode_hs,
                     hbp: bus.mode_hbp, vfp: bus.mode_vfp, vs: bus.mode_vs, vbp: bus.mode_vbp,
                     interlaced: bus.mode_interlaced};

  assign bus.mode_ready = (state == S_IDLE) || (state == S_RUN);
  assign accept    = bus.mode_valid && bus.mode_ready;
  assign mode_good = mode_ok(bus.mode_h, bus.mode_v);
  assign desync    = (state == S_RUN) && synced_q && !bus.vram_synced;
  assign pix_open  = (state == S_RUN) || (state == S_WAIT_VB);

  always_comb begin
    state_nxt = state;
    hard_nxt  = hard;
    case (state)
      S_IDLE: begin
        // the first mode after reset has nothing running to protect, so it is always hard
        if (accept && mode_good) begin
          state_nxt = S_RESET;
          hard_nxt  = 1'b1;
        end
      end
      S_RUN: begin
        if (accept && mode_good) begin
          state_nxt = bus.mode_hard ? S_RESET : S_WAIT_VB;
          hard_nxt  = bus.mode_hard;
        end
`ifdef GROOVY_VGA_AUTORESYNC_EN
        else if (desync) begin
          state_nxt = S_WAIT_VB;
          hard_nxt  = 1'b0;
        end
`endif
      end
      S_WAIT_VB: if ((bus.vblank && !vblank_q) || (cnt >= WAIT_LAST)) state_nxt = S_RESET;
      S_RESET:   if (cnt >= RESET_LAST) state_nxt = S_SETTLE;
      S_SETTLE:  if (cnt >= SETTLE_LAST) state_nxt = S_RUN;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      hard         <= 1'b0;
      cnt          <= '0;
      shadow       <= '0;
      active       <= '0;
      vblank_q     <= 1'b0;
      end_frame_q  <= 1'b0;
      synced_q     <= 1'b0;
      mode_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      wait_vb_q    <= 1'b0;
      desync_q     <= '0;
    end else begin
      state       <= state_nxt;
      hard        <= hard_nxt;
      cnt         <= (state_nxt != state) ? 24'd0 : cnt + 24'd1;
      vblank_q    <= bus.vblank;
      end_frame_q <= bus.vram_end_frame;
      synced_q    <= bus.vram_synced;
      if (accept && mode_good) shadow <= mode_in;
`ifdef GROOVY_VGA_AUTORESYNC_EN
      else if (desync) shadow <= active;
`endif
      // timing outputs only ever change on the first reset cycle, while the vga is held in reset
      if ((state == S_RESET) && (cnt == 24'd0)) active <= shadow;
      mode_err_q   <= accept && !mode_good;
      frame_done_q <= pix_open && bus.vram_end_frame && !end_frame_q;
      wait_vb_q    <= desync;
      if (desync && (desync_q != 16'hFFFF)) desync_q <= desync_q + 16'd1;
    end
  end

  assign bus.H          = active.h;
  assign bus.V          = active.v;
  assign bus.HFP        = active.hfp;
  assign bus.HS         = active.hs;
  assign bus.HBP        = active.hbp;
  assign bus.VFP        = active.vfp;
  assign bus.VS         = active.vs;
  assign bus.VBP        = active.vbp;
  assign bus.interlaced = active.interlaced;

  assign bus.vga_reset       = (state == S_IDLE) || ((state == S_RESET) && hard);
  assign bus.vga_soft_reset  = (state == S_RESET) && !hard;
  assign bus.vga_frame_reset = (state == S_RESET);
  assign bus.vram_reset      = (state == S_IDLE) || (state == S_RESET);
  assign bus.vram_active     = pix_open;
  assign bus.vga_wait_vblank = wait_vb_q;
  assign bus.mode_err        = mode_err_q;
  assign bus.frame_done      = frame_done_q;
  assign bus.desync_cnt      = desync_q;
  assign bus.state           = state;

  vga_mode_ctrl_pixreg u_pixreg (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .open       (pix_open),
    .vram_ready (bus.vram_ready),
    .pix_valid  (bus.pix_valid),
    .pix_rgb    (bus.pix_rgb),
    .pix_ready  (bus.pix_ready),
    .vram_req   (bus.vram_req),
    .r_vram_in  (bus.r_vram_in),
    .g_vram_in  (bus.g_vram_in),
    .b_vram_in  (bus.b_vram_in)
  );

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl; instance b uses a short wait timeout for the forced-apply case.
module tb_vga_mode_ctrl;

  logic clk_sys = 1'b0;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  always #5 clk_sys = ~clk_sys;

  vga_mode_ctrl_if bus_a ();
  vga_mode_ctrl_if bus_b ();

  vga_mode_ctrl #(.RESET_CYCLES(4), .SETTLE_CYCLES(2), .WAIT_TIMEOUT(24'd1000)) u_dut_a (
    .clk_sys (clk_sys), .reset_n (rst_a_n), .bus (bus_a));

  vga_mode_ctrl #(.RESET_CYCLES(4), .SETTLE_CYCLES(2), .WAIT_TIMEOUT(24'd16)) u_dut_b (
    .clk_sys (clk_sys), .reset_n (rst_b_n), .bus (bus_b));

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_a(input logic [15:0] h, input logic [15:0] v, input logic hard);
    bus_a.mode_h = h; bus_a.mode_v = v; bus_a.mode_hard = hard; bus_a.mode_valid = 1'b1;
    tick();
    bus_a.mode_valid = 1'b0;
  endtask

  task automatic wait_run_a(input string tag);
    int n = 0;
    while (bus_a.state != 3'd4 && n < 40) begin tick(); n++; end
    check(tag, 32'(bus_a.state), 32'd4);
  endtask

  task automatic wait_run_b(input string tag);
    int n = 0;
    while (bus_b.state != 3'd4 && n < 40) begin tick(); n++; end
    check(tag, 32'(bus_b.state), 32'd4);
  endtask

  initial begin
    int leave, sc, sent, got, adj, w;
    logic prev;
    logic [23:0] expq[$];
    logic [23:0] e;

    {bus_a.mode_valid, bus_a.mode_hard, bus_a.vblank, bus_a.vram_ready, bus_a.vram_end_frame,
     bus_a.vram_synced, bus_a.pix_valid} = '0;
    {bus_b.mode_valid, bus_b.mode_hard, bus_b.vblank, bus_b.vram_ready, bus_b.vram_end_frame,
     bus_b.vram_synced, bus_b.pix_valid} = '0;
    bus_a.pix_rgb = '0; bus_b.pix_rgb = '0;
    bus_a.mode_hfp = 8'd16; bus_a.mode_hs = 8'd96; bus_a.mode_hbp = 8'd48;
    bus_a.mode_vfp = 8'd10; bus_a.mode_vs = 8'd2;  bus_a.mode_vbp = 8'd33;
    bus_a.mode_interlaced = 8'd0; bus_a.mode_h = '0; bus_a.mode_v = '0;
    bus_b.mode_hfp = 8'd16; bus_b.mode_hs = 8'd96; bus_b.mode_hbp = 8'd48;
    bus_b.mode_vfp = 8'd10; bus_b.mode_vs = 8'd2;  bus_b.mode_vbp = 8'd33;
    bus_b.mode_interlaced = 8'd0; bus_b.mode_h = '0; bus_b.mode_v = '0;

    // reset values
    tick(); tick();
    check("rst_state", 32'(bus_a.state), 32'd0);
    check("rst_vga_reset", 32'(bus_a.vga_reset), 32'd1);
    check("rst_vram_reset", 32'(bus_a.vram_reset), 32'd1);
    check("rst_mode_ready", 32'(bus_a.mode_ready), 32'd1);
    check("rst_H", 32'(bus_a.H), 32'd0);
    check("rst_vram_active", 32'(bus_a.vram_active), 32'd0);
    check("rst_pix_ready", 32'(bus_a.pix_ready), 32'd0);
    check("rst_desync_cnt", 32'(bus_a.desync_cnt), 32'd0);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    tick();

    // 1: first modeline from idle is applied hard
    send_a(16'd640, 16'd480, 1'b0);
    check("t1_state_reset", 32'(bus_a.state), 32'd2);
    check("t1_H_before_apply", 32'(bus_a.H), 32'd0);
    sc = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus_a.state == 3'd2 && bus_a.vga_reset && !bus_a.vga_soft_reset && bus_a.vram_reset) sc++;
      tick();
    end
    check("t1_hard_reset_cycles", 32'(sc), 32'd4);
    check("t1_state_settle", 32'(bus_a.state), 32'd3);
    check("t1_vga_reset_low", 32'(bus_a.vga_reset), 32'd0);
    check("t1_H", 32'(bus_a.H), 32'd640);
    check("t1_V", 32'(bus_a.V), 32'd480);
    check("t1_porches", {bus_a.HFP, bus_a.HS, bus_a.HBP, bus_a.VFP}, {8'd16, 8'd96, 8'd48, 8'd10});
    check("t1_vporch", {bus_a.VS, bus_a.VBP, bus_a.interlaced}, {8'd2, 8'd33, 8'd0});
    check("t1_active_settle", 32'(bus_a.vram_active), 32'd0);
    tick();
    check("t1_active_settle2", 32'(bus_a.vram_active), 32'd0);
    tick();
    check("t1_state_run", 32'(bus_a.state), 32'd4);
    check("t1_vram_active", 32'(bus_a.vram_active), 32'd1);
    check("t1_mode_ready", 32'(bus_a.mode_ready), 32'd1);

    // 2: soft modeline waits for the vblank edge
    send_a(16'd320, 16'd240, 1'b0);
    check("t2_state_wait", 32'(bus_a.state), 32'd1);
    check("t2_mode_ready_low", 32'(bus_a.mode_ready), 32'd0);
    leave = 0;
    repeat (100) begin
      if (bus_a.state != 3'd1 || bus_a.H != 16'd640) leave++;
      tick();
    end
    check("t2_hold_until_vblank", 32'(leave), 32'd0);
    bus_a.vblank = 1'b1;
    tick();
    check("t2_state_reset", 32'(bus_a.state), 32'd2);
    sc = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus_a.state == 3'd2 && bus_a.vga_soft_reset && !bus_a.vga_reset && bus_a.vga_frame_reset) sc++;
      tick();
    end
    check("t2_soft_reset_cycles", 32'(sc), 32'd4);
    check("t2_soft_reset_low", 32'(bus_a.vga_soft_reset), 32'd0);
    check("t2_H", 32'(bus_a.H), 32'd320);
    check("t2_V", 32'(bus_a.V), 32'd240);
    bus_a.vblank = 1'b0;
    wait_run_a("t2_back_to_run");

    // 3: pixel streaming
    bus_a.vram_ready = 1'b1;
    sent = 0; got = 0; adj = 0; prev = 1'b0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      bus_a.pix_valid = (sent < 10);
      bus_a.pix_rgb   = 24'h112233 + 24'(sent);
      #1;
      if (bus_a.pix_valid && bus_a.pix_ready) begin expq.push_back(bus_a.pix_rgb); sent++; end
      tick();
      if (bus_a.vram_req) begin
        got++;
        if (prev) adj++;
        e = (expq.size() > 0) ? expq.pop_front() : 24'hxxxxxx;
        check("t3_pix_data", {8'd0, bus_a.r_vram_in, bus_a.g_vram_in, bus_a.b_vram_in}, {8'd0, e});
      end
      prev = bus_a.vram_req;
    end
    bus_a.pix_valid = 1'b0;
    check("t3_req_count", 32'(got), 32'd10);
    check("t3_no_adjacent", 32'(adj), 32'd0);
    tick(); tick();
    check("t3_data_hold", {8'd0, bus_a.r_vram_in, bus_a.g_vram_in, bus_a.b_vram_in}, 32'h0011223C);
    check("t3_req_idle", 32'(bus_a.vram_req), 32'd0);
    bus_a.vram_ready = 1'b0; bus_a.pix_valid = 1'b1;
    #1;
    check("t3_ready_drop", 32'(bus_a.pix_ready), 32'd0);
    bus_a.pix_valid = 1'b0; bus_a.vram_ready = 1'b1;

    // 4: rejected modeline
    send_a(16'd800, 16'd0, 1'b1);
    check("t4_mode_err", 32'(bus_a.mode_err), 32'd1);
    check("t4_state_run", 32'(bus_a.state), 32'd4);
    check("t4_H", 32'(bus_a.H), 32'd320);
    check("t4_V", 32'(bus_a.V), 32'd240);
    tick();
    check("t4_mode_err_pulse", 32'(bus_a.mode_err), 32'd0);

    // frame completion
    bus_a.vram_end_frame = 1'b1;
    tick();
    check("fd_pulse", 32'(bus_a.frame_done), 32'd1);
    tick();
    check("fd_single", 32'(bus_a.frame_done), 32'd0);
    bus_a.vram_end_frame = 1'b0;

    // 5: desync events
    bus_a.vram_synced = 1'b1;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      bus_a.vram_synced = 1'b0;
      tick();
      check("t5_wait_vblank", 32'(bus_a.vga_wait_vblank), 32'd1);
      check("t5_desync_cnt", 32'(bus_a.desync_cnt), 32'(k + 1));
`ifdef GROOVY_VGA_AUTORESYNC_EN
      check("t5_state", 32'(bus_a.state), 32'd1);
`else
      check("t5_state", 32'(bus_a.state), 32'd4);
`endif
      tick();
      check("t5_wait_vblank_pulse", 32'(bus_a.vga_wait_vblank), 32'd0);
      bus_a.vram_synced = 1'b1; bus_a.vblank = 1'b1;
      tick();
      bus_a.vblank = 1'b0;
      wait_run_a("t5_run");
    end
    check("t5_desync_total", 32'(bus_a.desync_cnt), 32'd3);
    check("t5_H_kept", 32'(bus_a.H), 32'd320);

    // 6: forced apply after timeout, then reset mid S_RESET (instance b)
    bus_b.mode_h = 16'd640; bus_b.mode_v = 16'd480; bus_b.mode_hard = 1'b0; bus_b.mode_valid = 1'b1;
    tick();
    bus_b.mode_valid = 1'b0;
    check("t6_idle_hard", 32'(bus_b.vga_reset), 32'd1);
    wait_run_b("t6_run");
    bus_b.mode_h = 16'd1024; bus_b.mode_v = 16'd768; bus_b.mode_valid = 1'b1;
    tick();
    bus_b.mode_valid = 1'b0;
    w = 0;
    while (bus_b.state == 3'd1 && w < 40) begin w++; tick(); end
    check("t6_wait_cycles", 32'(w), 32'd16);
    check("t6_forced_reset", 32'(bus_b.state), 32'd2);
    check("t6_H_old", 32'(bus_b.H), 32'd640);
    tick();
    check("t6_H_new", 32'(bus_b.H), 32'd1024);
    rst_b_n = 1'b0;
    #1;
    check("t6_rst_state", 32'(bus_b.state), 32'd0);
    check("t6_rst_vga_reset", 32'(bus_b.vga_reset), 32'd1);
    check("t6_rst_vram_reset", 32'(bus_b.vram_reset), 32'd1);
    check("t6_rst_frame_reset", 32'(bus_b.vga_frame_reset), 32'd0);
    check("t6_rst_H", 32'(bus_b.H), 32'd0);
    tick();
    rst_b_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_mode_ctrl.md
Name: vga_mode_ctrl

Overview:
- Sequencer in front of the vga/vram video block.
- Accepts modelines from the host command path and applies them glitch-free at vblank, or immediately on a hard switch.
- Drives the vga reset family (vga_reset, vga_soft_reset, vga_frame_reset, vram_reset, vga_wait_vblank) and vram_active.
- Paces the incoming pixel stream into vram writes against vram_ready, and reports frame completion and desync events.

Parameters:
RESET_CYCLES, 4, cycles the reset outputs stay asserted in S_RESET (min 1)
SETTLE_CYCLES, 2, quiet cycles in S_SETTLE before S_RUN
WAIT_TIMEOUT, 24'h400000, max clk_sys cycles in S_WAIT_VB before a forced apply

Ports:
clk_sys  input  1  system clock; the only clock
reset_n  input  1  asynchronous, active-low reset
mode_valid/mode_ready  in/out  1  modeline handshake
mode_h, mode_v  input  16 each  visible width/height
mode_hfp, mode_hs, mode_hbp, mode_vfp, mode_vs, mode_vbp  input  8 each  porches/sync widths
mode_interlaced  input  8  interlace flag (nonzero = interlaced)
mode_hard  input  1  1 = apply immediately, no vblank wait
H, V  output  16 each  active timing to vga
HFP, HS, HBP, VFP, VS, VBP, interlaced  output  8 each  active timing to vga
vga_reset, vga_soft_reset, vga_frame_reset, vram_reset, vga_wait_vblank  output  1  vga control
vram_active  output  1  vga sources pixels from vram
vblank, vram_ready, vram_end_frame, vram_synced  input  1  vga status
pix_valid/pix_ready  in/out  1  upstream pixel handshake
pix_rgb  input  24  {r,g,b}
vram_req  output  1  one-cycle vram write strobe
r_vram_in, g_vram_in, b_vram_in  output  8 each  pixel data to vga
frame_done  output  1  one-cycle pulse per complete vram frame
mode_err  output  1  one-cycle pulse when a modeline is rejected
desync_cnt  output  16  saturating vram desync counter
state  output  3  current FSM state (debug)

Behaviour:
- Reset (async, reset_n=0) state: S_IDLE. All timing outputs 0.
- Reset values, outputs 1: vga_reset, vram_reset, mode_ready.
- Reset values, outputs 0: every other output, including counters.
- States: S_IDLE=0, S_WAIT_VB=1, S_RESET=2, S_SETTLE=3, S_RUN=4.
- mode_ready=1 only in S_IDLE and S_RUN.
- Accept = mode_valid&&mode_ready. On accept, all mode_* inputs latch into shadow registers that cycle.
- mode_h==0 or mode_v==0: the modeline is consumed but rejected. mode_err pulses next cycle; state, shadow and active timing are unchanged.
- S_IDLE:
  - vga_reset=1, vram_reset=1.
  - Valid accept -> S_RESET, with hard=1 regardless of mode_hard.
- S_RUN:
  - Valid accept with mode_hard=1 -> S_RESET (hard).
  - Valid accept with mode_hard=0 -> S_WAIT_VB (soft).
- S_WAIT_VB:
  - vblank rising edge (registered previous vblank) -> S_RESET.
  - WAIT_TIMEOUT cycles elapsed -> S_RESET (forced apply).
  - Pixel path stays open.
- S_RESET:
  - First cycle: shadow copies into the active timing outputs. Timing outputs change only here.
  - For RESET_CYCLES cycles assert vram_reset, vga_frame_reset, and vga_reset (hard) or vga_soft_reset (soft).
  - vram_active=0, pix_ready=0. The in-flight vram_req still completes.
  - Then -> S_SETTLE.
- S_SETTLE: all resets low; after SETTLE_CYCLES -> S_RUN, and vram_active=1 from that cycle.
- Pixel path:
  - pix_ready = (S_RUN||S_WAIT_VB) && vram_ready && !vram_req.
  - On accept, the next cycle has vram_req=1 and r/g/b_vram_in = pix_rgb[23:16]/[15:8]/[7:0]. The data holds until the next accept.
  - Throughput is at most 1 pixel per 2 clk_sys.
  - At most one outstanding request, so vram_ready cannot be overrun.
- frame_done: pulses on a vram_end_frame rising edge in S_RUN/S_WAIT_VB.
- Desync (vram_synced 1->0 in S_RUN):
  - desync_cnt increments, saturating at 16'hFFFF.
  - vga_wait_vblank pulses for one cycle.
- vram_synced falling in the same cycle as an accept: both actions occur.
- reset_n low mid-operation: immediate return to S_IDLE with the reset values above. The shadow is cleared.

Optional Feature:
- Macro: GROOVY_VGA_AUTORESYNC_EN.
- Defined: a desync in S_RUN also forces S_WAIT_VB and a soft re-apply of the current active timing. The shadow is reloaded from the active timing, and mode_ready=0 until back in S_RUN.
- Undefined: counting plus the vga_wait_vblank pulse only; the FSM is unaffected.

Decomposition:
- Package vga_mode_ctrl_pkg holds:
  - state encodings S_IDLE..S_RUN;
  - modeline_t struct (h, v, hfp, hs, hbp, vfp, vs, vbp, interlaced);
  - MODE_H_MIN=1 and MODE_V_MIN=1 constants.
- Sub-module vga_mode_ctrl_pixreg holds the pixel request register: pix handshake, vram_req and data hold.

Test Plan:
1. From reset, send modeline 640/16/96/48, 480/10/2/33, interlaced=0 -> S_IDLE->S_RESET; vga_reset=1 for 4 cycles; H=640, V=480 latched; vram_active=1 after 2 settle cycles; mode_ready=1.
2. In S_RUN, send soft modeline 320x240 with vblank held low for 100 cycles then raised -> timing unchanged until the vblank edge; then vga_soft_reset high for 4 cycles; H=320.
3. Stream 10 pixels, 24'h112233 upward, with vram_ready=1 -> exactly 10 vram_req pulses, none adjacent; data matches per pulse. Drop vram_ready -> pix_ready=0 the same cycle.
4. Send mode_v=0 -> mode_err pulse; H and V unchanged; state stays S_RUN.
5. Toggle vram_synced 1->0 three times -> desync_cnt=3 and three vga_wait_vblank pulses. With GROOVY_VGA_AUTORESYNC_EN, each desync is followed by a soft re-apply at the next vblank.
6. Hold vblank low in S_WAIT_VB with WAIT_TIMEOUT=16 -> forced S_RESET after 16 cycles. Assert reset_n=0 mid-S_RESET -> immediate S_IDLE with vga_reset=1.
